// File: rtl/norm_shift_sequencer.sv
// Normalization sequencer: left-shifts a significand one bit per cycle through an
// external shifter until its MSB is set or the captured shift limit is reached.
module norm_shift_sequencer #(
   parameter int SWR = 26,
   parameter int EWR = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic [SWR-1:0] Data_i,
   input  logic [EWR-1:0] Max_Shift_i,
   output logic [SWR-1:0] shft_data_o,
   output logic           shft_sel_o,
   output logic           shft_bit_o,
   input  logic [SWR-1:0] shft_data_i,
   output logic           ready_o,
   output logic           valid_o,
   output logic [SWR-1:0] Data_o,
   output logic [EWR-1:0] Shift_Count_o,
   output logic           zero_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [SWR-1:0] work_q, work_d;
   logic [EWR-1:0] cnt_q, cnt_d;
   logic [EWR-1:0] lim_q, lim_d;
   logic           zero_q, zero_d;
   logic [SWR-1:0] data_out_q, data_out_d;
   logic [EWR-1:0] shift_count_q, shift_count_d;
   logic           zero_out_q, zero_out_d;
   logic           valid_q, valid_d;
   logic           ready_q, ready_d;
   logic           shift_take_s;

   // Next-state, working register and result capture
   always_comb begin
      state_d       = state_q;
      work_d        = work_q;
      cnt_d         = cnt_q;
      lim_d         = lim_q;
      zero_d        = zero_q;
      data_out_d    = data_out_q;
      shift_count_d = shift_count_q;
      zero_out_d    = zero_out_q;
      shift_take_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               work_d = Data_i;
               lim_d  = Max_Shift_i;
               cnt_d  = {EWR{1'b0}};
               if (Data_i == {SWR{1'b0}}) begin
                  zero_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  zero_d  = 1'b0;
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // MSB set or limit reached ends the loop; the limit also bounds the counter
            if (work_q[SWR-1] || (cnt_q == lim_q)) begin
               state_d = DONE;
            end else begin
               shift_take_s = 1'b1;
               work_d       = shft_data_i;
               cnt_d        = cnt_q + {{(EWR-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == DONE) && (state_q != DONE)) begin
         data_out_d    = work_d;
         shift_count_d = cnt_d;
         zero_out_d    = zero_d;
      end else begin
         data_out_d    = data_out_q;
         shift_count_d = shift_count_q;
         zero_out_d    = zero_out_q;
      end

      valid_d = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         work_q        <= {SWR{1'b0}};
         cnt_q         <= {EWR{1'b0}};
         lim_q         <= {EWR{1'b0}};
         zero_q        <= 1'b0;
         data_out_q    <= {SWR{1'b0}};
         shift_count_q <= {EWR{1'b0}};
         zero_out_q    <= 1'b0;
         valid_q       <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         work_q        <= work_d;
         cnt_q         <= cnt_d;
         lim_q         <= lim_d;
         zero_q        <= zero_d;
         data_out_q    <= data_out_d;
         shift_count_q <= shift_count_d;
         zero_out_q    <= zero_out_d;
         valid_q       <= valid_d;
         ready_q       <= ready_d;
      end
   end

   assign shft_data_o   = work_q;
   assign shft_sel_o    = shift_take_s;
   assign shft_bit_o    = 1'b0;
   assign ready_o       = ready_q;
   assign valid_o       = valid_q;
   assign Data_o        = data_out_q;
   assign Shift_Count_o = shift_count_q;
   assign zero_o        = zero_out_q;

endmodule

// File: tb/tb_norm_shift_sequencer.sv
// Scoreboard bench for norm_shift_sequencer: directed vectors push expected results,
// a negedge monitor pops and compares on every valid_o pulse.
module tb_norm_shift_sequencer;

   localparam int SWR = 26;
   localparam int EWR = 5;

   logic           clk;
   logic           rst;
   logic           start_i;
   logic [SWR-1:0] Data_i;
   logic [EWR-1:0] Max_Shift_i;
   logic [SWR-1:0] shft_data_o;
   logic           shft_sel_o;
   logic           shft_bit_o;
   logic [SWR-1:0] shft_data_i;
   logic           ready_o;
   logic           valid_o;
   logic [SWR-1:0] Data_o;
   logic [EWR-1:0] Shift_Count_o;
   logic           zero_o;

   typedef struct packed {
      logic [SWR-1:0] data;
      logic [EWR-1:0] cnt;
      logic           zero;
      logic [31:0]    due;
   } exp_t;

   exp_t        exp_q[$];
   int          checks;
   int          errors;
   logic [31:0] cyc;

   norm_shift_sequencer #(.SWR(SWR), .EWR(EWR)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .Data_i       (Data_i),
      .Max_Shift_i  (Max_Shift_i),
      .shft_data_o  (shft_data_o),
      .shft_sel_o   (shft_sel_o),
      .shft_bit_o   (shft_bit_o),
      .shft_data_i  (shft_data_i),
      .ready_o      (ready_o),
      .valid_o      (valid_o),
      .Data_o       (Data_o),
      .Shift_Count_o(Shift_Count_o),
      .zero_o       (zero_o)
   );

   // External 1-bit left shifter with select
   assign shft_data_i = shft_sel_o ? {shft_data_o[SWR-2:0], shft_bit_o} : shft_data_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every valid_o pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d expected no result", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("latency",     cyc,                     e.due);
            check("Data_o",      {6'd0, Data_o},          {6'd0, e.data});
            check("Shift_Count", {27'd0, Shift_Count_o},  {27'd0, e.cnt});
            check("zero_o",      {31'd0, zero_o},         {31'd0, e.zero});
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
   endtask

   task automatic start_op(input logic [SWR-1:0] d, input logic [EWR-1:0] lim,
                           input logic [SWR-1:0] ed, input logic [EWR-1:0] ec,
                           input logic ez, input int lat);
      exp_t e;
      @(posedge clk);
      #1;
      check("ready_before_start", {31'd0, ready_o}, 32'd1);
      start_i     = 1'b1;
      Data_i      = d;
      Max_Shift_i = lim;
      e.data = ed;
      e.cnt  = ec;
      e.zero = ez;
      e.due  = cyc + lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cyc         = 32'd0;
      rst         = 1'b1;
      start_i     = 1'b0;
      Data_i      = '0;
      Max_Shift_i = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_ready",   {31'd0, ready_o},       32'd1);
      check("reset_valid",   {31'd0, valid_o},       32'd0);
      check("reset_data",    {6'd0, Data_o},         32'd0);
      check("reset_count",   {27'd0, Shift_Count_o}, 32'd0);
      check("reset_zero",    {31'd0, zero_o},        32'd0);
      check("reset_shft_do", {6'd0, shft_data_o},    32'd0);

      start_op(26'h0400000, 5'd31, 26'h2000000, 5'd3,  1'b0, 5);
      wait_drain();
      start_op(26'h2ABCDEF, 5'd31, 26'h2ABCDEF, 5'd0,  1'b0, 2);
      wait_drain();
      start_op(26'h0000000, 5'd31, 26'h0000000, 5'd0,  1'b1, 1);
      wait_drain();
      start_op(26'h0000001, 5'd4,  26'h0000010, 5'd4,  1'b0, 6);
      wait_drain();
      start_op(26'h0000001, 5'd31, 26'h2000000, 5'd25, 1'b0, 27);
      wait_drain();
      start_op(26'h0000100, 5'd0,  26'h0000100, 5'd0,  1'b0, 2);
      wait_drain();

      // start_i pulsed mid-SHIFT must be ignored
      start_op(26'h0008000, 5'd31, 26'h2000000, 5'd10, 1'b0, 12);
      @(posedge clk);
      #1;
      start_i = 1'b1;
      Data_i  = 26'h0000000;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_drain();
      repeat (3) @(posedge clk);

      // Reset at T+3 of a 10-shift operation: no result, outputs cleared
      start_op(26'h0008000, 5'd31, 26'h2000000, 5'd10, 1'b0, 12);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_ready", {31'd0, ready_o},       32'd1);
      check("abort_valid", {31'd0, valid_o},       32'd0);
      check("abort_data",  {6'd0, Data_o},         32'd0);
      check("abort_count", {27'd0, Shift_Count_o}, 32'd0);
      check("abort_zero",  {31'd0, zero_o},        32'd0);
      repeat (15) @(posedge clk);

      start_op(26'h0000003, 5'd31, 26'h3000000, 5'd24, 1'b0, 26);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/norm_shift_sequencer.md
NORM_SHIFT_SEQUENCER -- requirements
Module: norm_shift_sequencer

Interface
REQ-001 The block SHALL use parameter SWR, default 26, as the significand working width in bits.
REQ-002 The block SHALL use parameter EWR, default 5, as the shift-count width, with 2^EWR > SWR.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to normalize Data_i; sampled only in IDLE.
REQ-006 The block SHALL have port Data_i, input, SWR bits: unnormalized significand, captured with start_i.
REQ-007 The block SHALL have port Max_Shift_i, input, EWR bits: shift limit (exponent-underflow guard), captured with start_i.
REQ-008 The block SHALL have port shft_data_o, output, SWR bits: working register, driven to the external 1-bit left shifter Data_i.
REQ-009 The block SHALL have port shft_sel_o, output, 1 bit: shifter select; 1 selects the shifted value.
REQ-010 The block SHALL have port shft_bit_o, output, 1 bit: shifter fill bit, constant 0 (logical shift).
REQ-011 The block SHALL have port shft_data_i, input, SWR bits: shifter output, combinational from shft_data_o.
REQ-012 The block SHALL have port ready_o, output, 1 bit: 1 when in IDLE.
REQ-013 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse; result ports valid.
REQ-014 The block SHALL have port Data_o, output, SWR bits: normalized significand, registered.
REQ-015 The block SHALL have port Shift_Count_o, output, EWR bits: number of left shifts applied, registered.
REQ-016 The block SHALL have port zero_o, output, 1 bit: captured Data_i was all zeros, registered.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-018 In IDLE with start_i=1, the block SHALL capture Data_i into the working register, capture Max_Shift_i, and clear the count; it SHALL go to DONE with zero flag set if Data_i==0, else go to SHIFT.
REQ-019 In IDLE with start_i=0, the block SHALL hold all registers.
REQ-020 In SHIFT, the block SHALL go to DONE if working[SWR-1]==1 or count==captured limit; otherwise it SHALL load working<=shft_data_i and increment count, staying in SHIFT.
REQ-021 shft_sel_o SHALL be 1 only in SHIFT when a shift is being taken that cycle, else 0; shft_data_o SHALL always equal the working register.
REQ-022 On entry to DONE, Data_o, Shift_Count_o and zero_o SHALL be updated from the working register, count and zero flag.
REQ-023 valid_o SHALL be 1 for exactly the DONE cycle, after which the FSM returns to IDLE.
REQ-024 Latency SHALL be: start at cycle T, N shifts needed -> valid_o at T+2+N; zero input -> valid_o at T+1 with Shift_Count_o=0.
REQ-025 The count SHALL never exceed the captured limit, and SHALL never exceed SWR-1 for nonzero input; the block SHALL have no counter wrap-around.
REQ-026 A limit of 0 SHALL produce no shift: Data_o=Data_i, count 0, valid_o at T+2.
REQ-027 start_i asserted in SHIFT or DONE SHALL be ignored with no queuing; start_i in the cycle after DONE (IDLE) SHALL be accepted.
REQ-028 Data_o, Shift_Count_o and zero_o SHALL hold their values until the next DONE.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL set state=IDLE, working register, count, Data_o, Shift_Count_o and zero_o to 0, and valid_o=0.
REQ-030 rst SHALL take priority over start_i and abort any operation in progress with no valid_o pulse; ready_o SHALL be 1 the cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover: Data_i=26'h0400000, Max_Shift_i=31, start at T -> valid_o at T+5, Data_o=26'h2000000, Shift_Count_o=3, zero_o=0.
REQ-032 The bench SHALL cover: Data_i=26'h2ABCDEF (MSB set) -> valid_o at T+2, Data_o unchanged, Shift_Count_o=0.
REQ-033 The bench SHALL cover: Data_i=0 -> valid_o at T+1, zero_o=1, Shift_Count_o=0, Data_o=0.
REQ-034 The bench SHALL cover: Data_i=26'h0000001, Max_Shift_i=4 -> valid_o at T+6, Data_o=26'h0000010, Shift_Count_o=4.
REQ-035 The bench SHALL cover: Data_i=26'h0000001, Max_Shift_i=31 -> valid_o at T+27, Data_o=26'h2000000, Shift_Count_o=25.
REQ-036 The bench SHALL cover: rst pulsed at T+3 during a 10-shift operation -> no valid_o, outputs 0, ready_o=1 at T+4; start_i pulsed mid-SHIFT -> ignored.
